// File: rtl/regfile_param_if.sv
// Register-file access bus: two read ports, one write port, clear request,
// registered read data with a valid strobe, and the clear-engine busy flag.
interface regfile_param_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic             rd_en;
    logic [AW-1:0]    rd_addr1;
    logic [AW-1:0]    rd_addr2;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             clr_req;
    logic [WIDTH-1:0] rd_data1;
    logic [WIDTH-1:0] rd_data2;
    logic             rd_valid;
    logic             busy;

    // Requester side (datapath / testbench).
    modport master (
        output rd_en, rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, clr_req,
        input  rd_data1, rd_data2, rd_valid, busy
    );

    // Register-file side.
    modport slave (
        input  rd_en, rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, clr_req,
        output rd_data1, rd_data2, rd_valid, busy
    );
endinterface

// File: rtl/regfile_param.sv
// Parametrised 2-read/1-write register file with registered reads, optional
// write-to-read bypass, optional hard-wired zero entry 0, and a clear engine
// that zeroes one entry per cycle after reset or on request.
module regfile_param #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 8,
    parameter bit          BYPASS    = 1'b1,
    parameter bit          ZERO_REG0 = 1'b0
) (
    input logic            clk,
    input logic            rst_n,
    regfile_param_if.slave bus
);
    localparam int unsigned   AW      = $clog2(DEPTH);
    // One extra bit so DEPTH itself is representable when it is a power of two.
    localparam logic [AW:0]   DepthW  = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LastIdx = AW'(DEPTH - 1);

    typedef enum logic [0:0] {StClear, StIdle} state_e;

    state_e           state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data1_q, rd_data1_d;
    logic [WIDTH-1:0] rd_data2_q, rd_data2_d;
    logic             rd_valid_q, rd_valid_d;

    logic             busy;
    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] rd1_val, rd2_val;
    logic             wr_ok;

    function automatic logic addr_ok(input logic [AW-1:0] addr);
        return ({1'b0, addr} < DepthW);
    endfunction

    // Entry is backed by storage (in range and not the hard-wired zero).
    function automatic logic addr_live(input logic [AW-1:0] addr);
        return addr_ok(addr) && !(ZERO_REG0 && (addr == '0));
    endfunction

    assign wr_ok = addr_live(bus.wr_addr);

    // Read values use pre-write array contents; bypass forwards this cycle's write data.
    assign rd1_val = !addr_live(bus.rd_addr1) ? '0 :
                     (BYPASS && bus.wr_en && (bus.rd_addr1 == bus.wr_addr)) ? bus.wr_data :
                     mem_q[bus.rd_addr1];
    assign rd2_val = !addr_live(bus.rd_addr2) ? '0 :
                     (BYPASS && bus.wr_en && (bus.rd_addr2 == bus.wr_addr)) ? bus.wr_data :
                     mem_q[bus.rd_addr2];

    // State register: FSM, clear index and registered read outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StClear;
            idx_q      <= '0;
            rd_data1_q <= '0;
            rd_data2_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            rd_data1_q <= rd_data1_d;
            rd_data2_q <= rd_data2_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Array storage: no reset, the clear engine zeroes it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // Next-state logic: walk idx through the array in CLEAR, enter CLEAR on request.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            StClear: begin
                if (idx_q == LastIdx) begin
                    state_d = StIdle;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StIdle: begin
                if (bus.clr_req) begin
                    state_d = StClear;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = StClear;
                idx_d   = '0;
            end
        endcase
    end

    // Output logic: array write port, read capture and valid strobe.
    always_comb begin
        busy       = (state_q == StClear);
        mem_we     = 1'b0;
        mem_waddr  = idx_q;
        mem_wdata  = '0;
        rd_valid_d = 1'b0;
        rd_data1_d = rd_data1_q;
        rd_data2_d = rd_data2_q;
        if (state_q == StClear) begin
            mem_we = 1'b1;
        end else if (!bus.clr_req) begin
            // A clear request takes priority over any access in the same cycle.
            if (bus.wr_en && wr_ok) begin
                mem_we    = 1'b1;
                mem_waddr = bus.wr_addr;
                mem_wdata = bus.wr_data;
            end
            if (bus.rd_en) begin
                rd_valid_d = 1'b1;
                rd_data1_d = rd1_val;
                rd_data2_d = rd2_val;
            end
        end
    end

    assign bus.busy     = busy;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data1 = rd_data1_q;
    assign bus.rd_data2 = rd_data2_q;
endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised multi-port register file: WIDTH-bit entries, DEPTH deep, two registered read ports and one write port, all usable in the same cycle. It generalises the team's 8x8 read-or-write register file with simultaneous read/write, optional write-to-read bypass, an optional hard-wired zero register, a `rd_valid` strobe, and a self-sequencing clear engine. The clear engine zeroes the array after reset and on request. It sits beside the datapath ALU as the operand store.

## Interface
Parameters:
- `WIDTH`, 8, data width of each entry (>=1).
- `DEPTH`, 8, number of entries (>=2; need not be a power of two).
- `BYPASS`, 1, 1 = a read of the address being written in the same cycle returns the new data; 0 = it returns the old data.
- `ZERO_REG0`, 0, 1 = entry 0 always reads 0 and writes to it are discarded.
- Local: `AW = $clog2(DEPTH)`.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `rd_en`  in  1  read request for both ports this cycle.
- `rd_addr1`  in  AW  read address, port 1.
- `rd_addr2`  in  AW  read address, port 2.
- `wr_en`  in  1  write request.
- `wr_addr`  in  AW  write address.
- `wr_data`  in  WIDTH  write data.
- `clr_req`  in  1  request a full-array clear.
- `rd_data1`  out  WIDTH  registered read data, port 1.
- `rd_data2`  out  WIDTH  registered read data, port 2.
- `rd_valid`  out  1  high for exactly one cycle when `rd_data1` and `rd_data2` were updated by a read.
- `busy`  out  1  clear engine active; reads and writes are ignored.

## Operation
- FSM states: CLEAR, IDLE. A clear counter `idx` (AW bits) runs in CLEAR.
- Reset (`rst_n`=0, asynchronous) forces:
  - state=CLEAR, idx=0;
  - `busy`=1, `rd_valid`=0, `rd_data1`=`rd_data2`=0.
  - Array contents are not reset directly; the clear engine zeroes them.
- CLEAR:
  - Each cycle writes 0 to entry idx, then idx increments.
  - After writing entry DEPTH-1, go to IDLE with idx=0.
  - `rd_en`, `wr_en` and `clr_req` are ignored; `rd_valid`=0; `rd_data1` and `rd_data2` hold their values.
- IDLE transitions:
  - `clr_req`=1 goes to CLEAR on the next edge.
  - With `clr_req`=1, that cycle's `rd_en` and `wr_en` are ignored (clear has priority).
- IDLE write: if `wr_en`=1, mem[wr_addr] is set to wr_data at the edge, with two exceptions, both discarded silently:
  - wr_addr >= DEPTH;
  - ZERO_REG0=1 and wr_addr=0.
- IDLE read: if `rd_en`=1, at the edge each port loads from its own address (port 1: rd_addr1; port 2: rd_addr2) using this priority:
  - 0 if the address >= DEPTH, or if ZERO_REG0=1 and the address is 0;
  - else `wr_data`, if BYPASS=1, `wr_en`=1 and the address equals wr_addr;
  - else mem[address] (pre-write contents).
- `rd_valid` follows `rd_en` from the previous cycle in IDLE.
- With `rd_en`=0, both outputs hold their last value. They are never X.
- Both ports may use the same address; both return the same value.

## Timing
- Read latency: 1 cycle. Address is sampled at edge N; data and `rd_valid`=1 are present from edge N until edge N+1.
- Write: takes effect at the sampling edge. A read issued in the next cycle returns the new data regardless of BYPASS.
- Clear duration: exactly DEPTH cycles.
  - `busy` rises at the edge sampling `clr_req`, or immediately on reset.
  - `busy` falls at the edge that writes entry DEPTH-1.
  - The first accepted access is in the cycle where `busy`=0.
- Reset released mid-clear, or asserted mid-clear: the clear restarts from idx=0.
- `clr_req` held high: one clear per IDLE cycle in which it is sampled. A held request re-triggers immediately after each clear completes.

## Test plan
- Reset release with DEPTH=8: `busy`=1 for exactly 8 cycles. Then reading all addresses returns 0 and `rd_data`=0 throughout.
- Write 0xA5 to addr 3, next cycle `rd_en` with addr1=3, addr2=3: one cycle later both outputs are 0xA5 and `rd_valid`=1 for one cycle.
- Simultaneous write 0x3C to addr 5 (old value 0x11) and read addr1=5: BYPASS=1 returns 0x3C; BYPASS=0 returns 0x11.
- ZERO_REG0=1: write 0xFF to addr 0, then read addr 0: returns 0x00. DEPTH=6 with a write/read at addr 7: no array change, read returns 0.
- After filling entries with nonzero data, pulse `clr_req` together with `wr_en`:
  - the write is dropped and `busy`=1 for DEPTH cycles;
  - `rd_en` during `busy` gives `rd_valid`=0;
  - all entries read 0 afterwards.
- Assert `rst_n`=0 mid-clear (idx=4): outputs go to 0 immediately. After release, `busy` stays high for a full DEPTH cycles.
